jpeg_block_sequencer: RTL and testbench

Sequences the coefficient stream from the entropy decoder into the coefficient-to-table stage, one 8x8 block at a time. It mirrors that stage's position and end-of-block rules so it knows when a block is complete. It then stalls the upstream stream until the block has been taken by the downstream IDCT/colour stage, and tracks block-in-MCU component, MCU x/y position and end-of-image.

---
 rtl/jpeg_block_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_jpeg_block_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_block_sequencer.sv
// Paces entropy-decoded coefficients into the coefficient-to-table stage one 8x8 block at a time,
// holds each finished block until the IDCT/colour stage takes it, and tracks MCU position.
// Optional chroma blocks per MCU: define BLOCK_SEQ_CHROMA_EN (default build is grayscale).
module jpeg_block_sequencer #(
    parameter int Y_BLOCKS = 4,
    parameter int DIM_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] mcu_cols,
    input  logic [DIM_W-1:0] mcu_rows,
    input  logic [3:0]       in_r_value,
    input  logic [7:0]       in_coefficient,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       tg_r_value,
    output logic [7:0]       tg_coefficient,
    output logic             tg_new_coefficient,
    input  logic             tg_table_valid,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic [1:0]       blk_comp,
    output logic             blk_last_in_mcu,
    output logic             blk_last_in_image,
    output logic [DIM_W-1:0] mcu_x,
    output logic [DIM_W-1:0] mcu_y,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       dbg_state
);

`ifdef BLOCK_SEQ_CHROMA_EN
    localparam int BLKS_PER_MCU = Y_BLOCKS + 2;
`else
    localparam int BLKS_PER_MCU = Y_BLOCKS;
`endif

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RUN        = 2'd1,
        WAIT_TABLE = 2'd2,
        WAIT_SINK  = 2'd3
    } state_t;

    state_t           state;
    logic [5:0]       pos;
    logic [2:0]       blk_idx;
    logic [DIM_W-1:0] cols_q;
    logic [DIM_W-1:0] rows_q;

    // Both handshakes: a beat moves on the rising edge where valid and ready are both high;
    // valid-side payload must hold until that edge, and ready never depends on valid.
    logic       xfer;
    logic [6:0] next_pos;
    logic       eob;
    logic       overrun;
    logic       block_end;
    logic       last_col;
    logic       last_row;
    logic       accept;

    assign xfer      = in_valid & in_ready;
    assign next_pos  = {1'b0, pos} + {3'b000, in_r_value} + 7'd1;
    assign eob       = (pos != 6'd0) && (in_r_value == 4'd0) && (in_coefficient == 8'd0);
    assign overrun   = next_pos > 7'd64;
    assign block_end = (next_pos >= 7'd64) || eob;

    assign tg_r_value         = in_r_value;
    assign tg_coefficient     = in_coefficient;
    assign tg_new_coefficient = xfer;

    assign last_col          = (mcu_x == cols_q - DIM_W'(1));
    assign last_row          = (mcu_y == rows_q - DIM_W'(1));
    assign blk_last_in_mcu   = (blk_idx == 3'(BLKS_PER_MCU - 1));
    assign blk_last_in_image = blk_last_in_mcu && last_col && last_row;
    assign accept            = blk_valid & blk_ready;
    assign dbg_state         = state;

`ifdef BLOCK_SEQ_CHROMA_EN
    always_comb begin
        blk_comp = 2'd2;
        if (blk_idx < 3'(Y_BLOCKS))
            blk_comp = 2'd0;
        else if (blk_idx == 3'(Y_BLOCKS))
            blk_comp = 2'd1;
    end
`else
    assign blk_comp = 2'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pos       <= '0;
            blk_idx   <= '0;
            mcu_x     <= '0;
            mcu_y     <= '0;
            cols_q    <= '0;
            rows_q    <= '0;
            in_ready  <= 1'b0;
            blk_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cols_q  <= mcu_cols;
                        rows_q  <= mcu_rows;
                        pos     <= '0;
                        blk_idx <= '0;
                        mcu_x   <= '0;
                        mcu_y   <= '0;
                        if (mcu_cols == '0 || mcu_rows == '0) begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            err      <= 1'b0;
                            state    <= RUN;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // The table stage only completes a block after we close it.
                    if (tg_table_valid)
                        err <= 1'b1;
                    if (xfer) begin
                        if (overrun)
                            err <= 1'b1;
                        if (block_end) begin
                            pos      <= '0;
                            state    <= WAIT_TABLE;
                            in_ready <= 1'b0;
                        end else begin
                            pos <= next_pos[5:0];
                        end
                    end
                end
                WAIT_TABLE: begin
                    if (tg_table_valid) begin
                        state     <= WAIT_SINK;
                        blk_valid <= 1'b1;
                    end
                end
                WAIT_SINK: begin
                    if (accept) begin
                        blk_valid <= 1'b0;
                        if (blk_last_in_mcu) begin
                            blk_idx <= '0;
                            if (last_col) begin
                                mcu_x <= '0;
                                mcu_y <= mcu_y + DIM_W'(1);
                            end else begin
                                mcu_x <= mcu_x + DIM_W'(1);
                            end
                        end else begin
                            blk_idx <= blk_idx + 3'd1;
                        end
                        if (blk_last_in_image) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= RUN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// Bench for jpeg_block_sequencer: random coefficient streams and sink stalls checked against
// a block-list scoreboard built from image dimensions and the block-end rules.
module tb_jpeg_block_sequencer;
  localparam int YB = 4;
  localparam int DW = 8;
`ifdef BLOCK_SEQ_CHROMA_EN
  localparam int BPM = YB + 2;
`else
  localparam int BPM = YB;
`endif

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] mcu_cols;
  logic [DW-1:0] mcu_rows;
  logic [3:0]    in_r_value;
  logic [7:0]    in_coefficient;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    tg_r_value;
  logic [7:0]    tg_coefficient;
  logic          tg_new_coefficient;
  logic          tg_table_valid;
  logic          blk_valid;
  logic          blk_ready;
  logic [1:0]    blk_comp;
  logic          blk_last_in_mcu;
  logic          blk_last_in_image;
  logic [DW-1:0] mcu_x;
  logic [DW-1:0] mcu_y;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    dbg_state;

  jpeg_block_sequencer #(.Y_BLOCKS(YB), .DIM_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .mcu_cols(mcu_cols), .mcu_rows(mcu_rows),
    .in_r_value(in_r_value), .in_coefficient(in_coefficient), .in_valid(in_valid),
    .in_ready(in_ready), .tg_r_value(tg_r_value), .tg_coefficient(tg_coefficient),
    .tg_new_coefficient(tg_new_coefficient), .tg_table_valid(tg_table_valid),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_comp(blk_comp),
    .blk_last_in_mcu(blk_last_in_mcu), .blk_last_in_image(blk_last_in_image),
    .mcu_x(mcu_x), .mcu_y(mcu_y), .busy(busy), .done(done), .err(err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: {comp[1:0], last_in_mcu, last_in_image, x[7:0], y[7:0]} per offered block
  logic [19:0] exp_q[$];
  logic [19:0] offer_obs;
  assign offer_obs = {blk_comp, blk_last_in_mcu, blk_last_in_image, mcu_x, mcu_y};

  int total = 0;
  int bad   = 0;
  int m_pos = 0;
  bit err_exp = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference block-end rule: returns 1 when this coefficient closes the block.
  function automatic bit model_step(input int r, input int c);
    int nxt;
    bit is_eob;
    nxt = m_pos + r + 1;
    is_eob = (m_pos != 0) && (r == 0) && (c == 0);
    if (nxt > 64) err_exp = 1'b1;
    if (nxt >= 64 || is_eob) begin
      m_pos = 0;
      return 1'b1;
    end
    m_pos = nxt;
    return 1'b0;
  endfunction

  // driver tasks: all called and returning at a falling edge
  task automatic start_image(input int cols, input int rows);
    mcu_cols = DW'(cols);
    mcu_rows = DW'(rows);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mcu_cols = '0;
    mcu_rows = '0;
    err_exp = 1'b0;
    m_pos = 0;
    check("start", {busy, in_ready, blk_valid, err, done, mcu_x, mcu_y}, {5'b11000, 16'h0});
  endtask

  task automatic send_coef(input int r, input int c);
    int n;
    n = 0;
    in_r_value = 4'(r);
    in_coefficient = 8'(c);
    in_valid = 1'b1;
    #1;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("xfer", {tg_new_coefficient, tg_r_value, tg_coefficient}, {1'b1, 4'(r), 8'(c)});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // kind 0: DC+EOB, 1: full 64, 2: run overflow from pos 60, 3: random
  task automatic send_block(input int kind);
    int n;
    int r;
    int c;
    bit fin;
    n = 0;
    fin = 1'b0;
    while (!fin) begin
      case (kind)
        0: begin r = 0; c = (n == 0) ? 5 : 0; end
        1: begin r = 0; c = $urandom_range(1, 255); end
        2: begin
          r = (n == 0) ? 0 : (n < 4) ? 14 : (n == 4) ? 13 : 7;
          c = $urandom_range(1, 255);
        end
        default: begin
          if (m_pos != 0 && $urandom_range(0, 7) == 0) begin
            r = 0; c = 0;
          end else begin
            r = $urandom_range(0, 15); c = $urandom_range(0, 255);
          end
        end
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_coef(r, c);
      fin = model_step(r, c);
      n++;
    end
  endtask

  task automatic close_block();
    check("wait_table", {in_ready, blk_valid, busy, tg_new_coefficient}, 4'b0010);
    tg_table_valid = 1'b1;
    @(negedge clk);
    tg_table_valid = 1'b0;
  endtask

  task automatic run_image(input int cols, input int rows, input int mode);
    logic [19:0] exp;
    int nblk;
    int kind;
    int stall;
    start_image(cols, rows);
    if (mode == 2) begin
      tg_table_valid = 1'b1;
      @(negedge clk);
      tg_table_valid = 1'b0;
      err_exp = 1'b1;
      check("table_in_run", {err, busy, in_ready}, 3'b111);
    end
    for (int y = 0; y < rows; y++)
      for (int x = 0; x < cols; x++)
        for (int b = 0; b < BPM; b++)
          exp_q.push_back({2'((b < YB) ? 0 : (b == YB) ? 1 : 2), 1'(b == BPM - 1),
                           1'(b == BPM - 1 && x == cols - 1 && y == rows - 1), 8'(x), 8'(y)});
    nblk = 0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      if (mode != 1) kind = 0;
      else if (nblk == 0) kind = 1;
      else if (nblk == 1) kind = 2;
      else kind = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 1) : 3;
      send_block(kind);
      close_block();
      stall = (nblk == 2) ? 10 : $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        in_valid = 1'b1;
        in_r_value = 4'($urandom_range(0, 15));
        in_coefficient = 8'($urandom_range(0, 255));
        #1;
        check("offer_hold", {blk_valid, in_ready, tg_new_coefficient, offer_obs}, {3'b100, exp});
        @(negedge clk);
      end
      in_valid = 1'b0;
      blk_ready = 1'b1;
      check("offer", {blk_valid, in_ready, offer_obs}, {2'b10, exp});
      check("err", err, err_exp);
      @(negedge clk);
      blk_ready = 1'b0;
      if (exp[16]) begin
        check("done", {done, busy, blk_valid, in_ready}, 4'b1000);
        @(negedge clk);
        check("done_once", {done, busy}, 2'b00);
      end else begin
        check("next_run", {done, busy, blk_valid, in_ready}, 4'b0101);
        if (mode == 1 && nblk == 1) begin
          mcu_cols = 8'd1;
          mcu_rows = 8'd1;
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          mcu_cols = '0;
          mcu_rows = '0;
          check("start_busy", {busy, in_ready, err}, {2'b11, err_exp});
        end
      end
      nblk++;
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mcu_cols = '0;
    mcu_rows = '0;
    in_r_value = '0;
    in_coefficient = '0;
    in_valid = 1'b0;
    tg_table_valid = 1'b0;
    blk_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset", {in_ready, blk_valid, done, err, busy, blk_comp, dbg_state, mcu_x, mcu_y},
          {9'b0, 16'h0});

    run_image(1, 1, 0);
    run_image(3, 2, 1);
    run_image(2, 1, 2);
    run_image(1, 2, 0);

    // reset while a block is offered
    start_image(2, 1);
    tg_table_valid = 1'b1;
    @(negedge clk);
    tg_table_valid = 1'b0;
    check("err_before_rst", err, 1'b1);
    m_pos = 0;
    send_block(0);
    close_block();
    check("sink_before_rst", {blk_valid, in_ready}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid", {busy, blk_valid, in_ready, done, err, mcu_x, mcu_y}, {5'b0, 16'h0});
    @(negedge clk);
    check("rst_no_done", {done, busy}, 2'b00);

    // zero dimension
    mcu_cols = 8'd0;
    mcu_rows = 8'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_dim", {done, err, busy, in_ready, dbg_state}, 6'b110000);
    @(negedge clk);
    check("zero_dim_after", {done, err, busy}, 3'b010);

    run_image($urandom_range(1, 3), $urandom_range(1, 3), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
